// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the dual-port line RAM arbiter.
// The optional performance counters are enabled with RAM_ARB_PERF_CNT_EN.
package ram_arb_pkg;

   localparam int DEF_N             = 32;
   localparam int DEF_WORDSPERLINE  = 2;
   localparam int DEF_ADDRESS_WIDTH = 10;
   localparam int DEF_NUM_REQ       = 4;
   localparam int PERF_W            = 32;

   typedef logic [DEF_WORDSPERLINE-1:0][DEF_N-1:0] line_t;

   typedef enum logic {PORT1, PORT2} port_sel_e;

   function automatic int req_idx_w(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

   function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
      return (en && (v != '1)) ? v + PERF_W'(1) : v;
   endfunction

endpackage

// File: rtl/line_ram_arbiter_rr_pick.sv
// Find-first-set over a request vector, scanning upward from a start index with wrap.
module rr_pick import ram_arb_pkg::*; #(
   parameter  int NUM_REQ = DEF_NUM_REQ,
   localparam int IW      = req_idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      start,
   output logic               found,
   output logic [IW-1:0]      idx
);

   always_comb begin
      int pos;
      // NOTE: every output gets a default before any branch, so no latch can be inferred.
      found = 1'b0;
      idx   = '0;
      pos   = 0;
      // Scan from farthest to nearest so the nearest hit is the last one written.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         pos = (int'(start) + k) % NUM_REQ;
         if (req[pos]) begin
            found = 1'b1;
            idx   = IW'(pos);
         end
      end
   end

endmodule

// File: rtl/line_ram_arbiter.sv
// Round-robin arbiter sharing one dual-port line RAM among NUM_REQ requesters, two grants per cycle.
// Define RAM_ARB_PERF_CNT_EN to add saturating grant/conflict counters on the perf ports.
module line_ram_arbiter import ram_arb_pkg::*; #(
   parameter int N             = DEF_N,
   parameter int WORDSPERLINE  = DEF_WORDSPERLINE,
   parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
   parameter int NUM_REQ       = DEF_NUM_REQ
) (
   input  logic                                            clk,
   input  logic                                            rst_n,
   input  logic [NUM_REQ-1:0]                              req_valid,
   input  logic [NUM_REQ-1:0]                              req_we,
   input  logic [NUM_REQ-1:0][ADDRESS_WIDTH-1:0]           req_addr,
   input  logic [NUM_REQ-1:0][WORDSPERLINE-1:0][N-1:0]     req_wdata,
   output logic [NUM_REQ-1:0]                              req_ready,
   output logic [NUM_REQ-1:0]                              rsp_valid,
   output logic [NUM_REQ-1:0][WORDSPERLINE-1:0][N-1:0]     rsp_rdata,
   output logic [ADDRESS_WIDTH-1:0]                        ram_addr1,
   output logic [ADDRESS_WIDTH-1:0]                        ram_addr2,
   output logic [WORDSPERLINE-1:0][N-1:0]                  ram_din1,
   output logic [WORDSPERLINE-1:0][N-1:0]                  ram_din2,
   output logic                                            ram_we1,
   output logic                                            ram_we2,
   input  logic [WORDSPERLINE-1:0][N-1:0]                  ram_dout1,
   input  logic [WORDSPERLINE-1:0][N-1:0]                  ram_dout2,
   output logic [NUM_REQ-1:0][PERF_W-1:0]                  perf_grant_cnt,
   output logic [PERF_W-1:0]                               perf_conflict_cnt
);

   localparam int IW = req_idx_w(NUM_REQ);

   typedef struct packed {
      logic          valid;
      logic [IW-1:0] idx;
   } pipe_t;

   function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
      return (int'(i) == NUM_REQ - 1) ? '0 : i + IW'(1);
   endfunction

   logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
   pipe_t              pipe_q [2];
   pipe_t              pipe_d [2];
   logic               a_found, b_found;
   logic [IW-1:0]      a_idx, b_idx;
   logic [NUM_REQ-1:0] b_cand;
   logic               b_conflict, a_grant, b_grant;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick_a (
      .req   (req_valid),
      .start (rr_ptr_q),
      .found (a_found),
      .idx   (a_idx)
   );

   // B may only take requesters lying between A and the wrap back to rr_ptr.
   always_comb begin
      int off_a;
      int off_i;
      b_cand = '0;
      off_a  = (int'(a_idx) - int'(rr_ptr_q) + NUM_REQ) % NUM_REQ;
      off_i  = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         off_i     = (i - int'(rr_ptr_q) + NUM_REQ) % NUM_REQ;
         b_cand[i] = req_valid[i] && a_found && (off_i > off_a);
      end
   end

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick_b (
      .req   (b_cand),
      .start (next_idx(a_idx)),
      .found (b_found),
      .idx   (b_idx)
   );

   always_comb begin
      b_conflict = a_found && b_found && (req_addr[a_idx] == req_addr[b_idx])
                   && (req_we[a_idx] || req_we[b_idx]);
      a_grant    = rst_n && a_found;
      b_grant    = rst_n && b_found && !b_conflict;
   end

   always_comb begin
      req_ready = '0;
      ram_addr1 = '0;
      ram_din1  = '0;
      ram_we1   = 1'b0;
      ram_addr2 = '0;
      ram_din2  = '0;
      ram_we2   = 1'b0;
      rr_ptr_d  = rr_ptr_q;
      pipe_d[PORT1] = '0;
      pipe_d[PORT2] = '0;
      if (a_grant) begin
         req_ready[a_idx] = 1'b1;
         ram_addr1        = req_addr[a_idx];
         ram_din1         = req_wdata[a_idx];
         ram_we1          = req_we[a_idx];
         pipe_d[PORT1]    = '{valid: !req_we[a_idx], idx: a_idx};
         rr_ptr_d         = next_idx(a_idx);
      end
      if (b_grant) begin
         req_ready[b_idx] = 1'b1;
         ram_addr2        = req_addr[b_idx];
         ram_din2         = req_wdata[b_idx];
         ram_we2          = req_we[b_idx];
         pipe_d[PORT2]    = '{valid: !req_we[b_idx], idx: b_idx};
         rr_ptr_d         = next_idx(b_idx);
      end
   end

   // NOTE: sequential state is updated only with non-blocking assignments.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_q      <= '0;
         pipe_q[PORT1] <= '0;
         pipe_q[PORT2] <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         pipe_q   <= pipe_d;
      end
   end

   // Responses are masked during reset so an in-flight read is dropped, not delivered late.
   always_comb begin
      rsp_valid = '0;
      rsp_rdata = '0;
      if (rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (pipe_q[PORT1].valid && (pipe_q[PORT1].idx == IW'(i))) begin
               rsp_valid[i] = 1'b1;
               rsp_rdata[i] = ram_dout1;
            end
            if (pipe_q[PORT2].valid && (pipe_q[PORT2].idx == IW'(i))) begin
               rsp_valid[i] = 1'b1;
               rsp_rdata[i] = ram_dout2;
            end
         end
      end
   end

`ifdef RAM_ARB_PERF_CNT_EN
   logic [NUM_REQ-1:0][PERF_W-1:0] perf_grant_q, perf_grant_d;
   logic [PERF_W-1:0]              perf_conflict_q, perf_conflict_d;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         perf_grant_d[i] = sat_inc(perf_grant_q[i], req_ready[i]);
      end
      perf_conflict_d = sat_inc(perf_conflict_q, rst_n && b_conflict);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_grant_q    <= '0;
         perf_conflict_q <= '0;
      end else begin
         perf_grant_q    <= perf_grant_d;
         perf_conflict_q <= perf_conflict_d;
      end
   end

   assign perf_grant_cnt    = perf_grant_q;
   assign perf_conflict_cnt = perf_conflict_q;
`else
   assign perf_grant_cnt    = '0;
   assign perf_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_line_ram_arbiter.sv
// Self-checking bench for line_ram_arbiter: directed scenarios followed by randomized traffic
// compared against a priority-order reference model and a shadow copy of the RAM contents.
module tb_line_ram_arbiter;
   import ram_arb_pkg::*;

   localparam int NR = DEF_NUM_REQ;
   localparam int AW = DEF_ADDRESS_WIDTH;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic [NR-1:0]            req_valid, req_we, req_ready, rsp_valid;
   logic [NR-1:0][AW-1:0]    req_addr;
   line_t [NR-1:0]           req_wdata, rsp_rdata;
   logic [AW-1:0]            ram_addr1, ram_addr2;
   line_t                    ram_din1, ram_din2, ram_dout1, ram_dout2;
   logic                     ram_we1, ram_we2;
   logic [NR-1:0][PERF_W-1:0] perf_grant_cnt;
   logic [PERF_W-1:0]        perf_conflict_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   line_t ram_mem [0:1023];
   line_t m_mem   [0:1023];
   int            m_ptr = 0;
   logic [NR-1:0] m_rv  = '0;
   line_t [NR-1:0] m_rd = '0;
   logic [NR-1:0] m_ready = '0;

   line_ram_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .ram_addr1(ram_addr1), .ram_addr2(ram_addr2), .ram_din1(ram_din1), .ram_din2(ram_din2),
      .ram_we1(ram_we1), .ram_we2(ram_we2), .ram_dout1(ram_dout1), .ram_dout2(ram_dout2),
      .perf_grant_cnt(perf_grant_cnt), .perf_conflict_cnt(perf_conflict_cnt)
   );

   always #5 clk = ~clk;

   // Dual-port RAM with registered read.
   always @(posedge clk) begin
      if (ram_we1) ram_mem[ram_addr1] <= ram_din1;
      else         ram_dout1 <= ram_mem[ram_addr1];
      if (ram_we2) ram_mem[ram_addr2] <= ram_din2;
      else         ram_dout2 <= ram_mem[ram_addr2];
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: walk requesters in priority order from the pointer, take the first two,
   // drop the second on a same-address clash involving a write.
   task automatic cycle(input string tag);
      int a, b, i;
      logic [NR-1:0]  e_ready, e_rv;
      line_t [NR-1:0] e_rd;
      logic [AW-1:0]  e_a1, e_a2;
      line_t          e_d1, e_d2;
      logic           e_w1, e_w2;
      #1;
      a = -1; b = -1;
      if (rst_n === 1'b1) begin
         for (int k = 0; k < NR; k++) begin
            i = (m_ptr + k) % NR;
            if (req_valid[i]) begin
               if (a < 0) a = i;
               else if (b < 0) b = i;
            end
         end
      end
      if (a >= 0 && b >= 0 && req_addr[a] == req_addr[b] && (req_we[a] || req_we[b])) b = -1;
      e_ready = '0; e_a1 = '0; e_a2 = '0; e_d1 = '0; e_d2 = '0; e_w1 = 1'b0; e_w2 = 1'b0;
      if (a >= 0) begin
         e_ready[a] = 1'b1; e_a1 = req_addr[a]; e_d1 = req_wdata[a]; e_w1 = req_we[a];
      end
      if (b >= 0) begin
         e_ready[b] = 1'b1; e_a2 = req_addr[b]; e_d2 = req_wdata[b]; e_w2 = req_we[b];
      end
      e_rv = (rst_n === 1'b1) ? m_rv : '0;
      e_rd = (rst_n === 1'b1) ? m_rd : '0;
      check({tag, ".ready"},     req_ready, e_ready);
      check({tag, ".we1"},       ram_we1,   e_w1);
      check({tag, ".we2"},       ram_we2,   e_w2);
      check({tag, ".addr1"},     ram_addr1, e_a1);
      check({tag, ".addr2"},     ram_addr2, e_a2);
      check({tag, ".din1"},      ram_din1,  e_d1);
      check({tag, ".din2"},      ram_din2,  e_d2);
      check({tag, ".rsp_valid"}, rsp_valid, e_rv);
      check({tag, ".rsp_rdata"}, rsp_rdata, e_rd);
      m_ready = e_ready;
      m_rv = '0;
      m_rd = '0;
      if (a >= 0 && !req_we[a]) begin m_rv[a] = 1'b1; m_rd[a] = m_mem[req_addr[a]]; end
      if (b >= 0 && !req_we[b]) begin m_rv[b] = 1'b1; m_rd[b] = m_mem[req_addr[b]]; end
      if (a >= 0 && req_we[a]) m_mem[req_addr[a]] = req_wdata[a];
      if (b >= 0 && req_we[b]) m_mem[req_addr[b]] = req_wdata[b];
      if (rst_n !== 1'b1) m_ptr = 0;
      else if (b >= 0)    m_ptr = (b + 1) % NR;
      else if (a >= 0)    m_ptr = (a + 1) % NR;
   endtask

   task automatic conflict_run(input string tag);
      @(negedge clk);
      req_valid = 4'b1010;
      req_we[1] = 1'b1; req_addr[1] = 10'h005; req_wdata[1] = 64'h1234;
      req_we[3] = 1'b0; req_addr[3] = 10'h005;
      cycle({tag, ".c0"});
      check({tag, ".only_req1"}, req_ready, 4'b0010);
      @(negedge clk);
      req_valid[1] = 1'b0;
      cycle({tag, ".c1"});
      check({tag, ".req3_next"}, req_ready, 4'b1000);
      @(negedge clk);
      req_valid = '0;
      cycle({tag, ".c2"});
      check({tag, ".rsp3_valid"}, rsp_valid, 4'b1000);
      check({tag, ".rsp3_data"},  rsp_rdata[3], 64'h1234);
   endtask

   task automatic new_reqs();
      for (int i = 0; i < NR; i++) begin
         if (m_ready[i] || !req_valid[i]) begin
            req_valid[i] = ($urandom_range(0, 3) != 0);
            req_we[i]    = ($urandom_range(0, 2) == 0);
            req_addr[i]  = 10'($urandom_range(0, 3));
            req_wdata[i] = {$urandom(), $urandom()};
         end else if ($urandom_range(0, 15) == 0) begin
            req_valid[i] = 1'b0;
         end
      end
   endtask

   initial begin
      int wait_cnt [NR];
      int max_wait;
      for (int i = 0; i < 1024; i++) begin
         ram_mem[i] = '0;
         m_mem[i]   = '0;
      end
      ram_mem[10'h010] = 64'hA; m_mem[10'h010] = 64'hA;
      ram_mem[10'h020] = 64'hB; m_mem[10'h020] = 64'hB;
      ram_dout1 = '0; ram_dout2 = '0;

      rst_n     = 1'b0;
      req_valid = '1;
      req_we    = '0;
      req_wdata = '0;
      for (int i = 0; i < NR; i++) req_addr[i] = 10'(10'h100 + i);

      repeat (3) begin
         @(negedge clk);
         cycle("reset");
         check("reset.no_ready", req_ready, 4'b0000);
         check("reset.no_we", {ram_we1, ram_we2}, 2'b00);
         check("reset.no_rsp", rsp_valid, 4'b0000);
      end

      @(negedge clk);
      rst_n = 1'b1;
      cycle("release");
      check("release.first_pair", req_ready, 4'b0011);
      check("release.port1_req0", ram_addr1, 10'h100);
      check("release.port2_req1", ram_addr2, 10'h101);
      @(negedge clk);
      req_valid = '0;
      cycle("release_rsp");

      @(negedge clk);
      req_valid = 4'b0101;
      req_we    = '0;
      req_addr[0] = 10'h010;
      req_addr[2] = 10'h020;
      cycle("two_reads");
      check("two_reads.both_ready", req_ready, 4'b0101);
      @(negedge clk);
      req_valid = '0;
      cycle("two_reads_rsp");
      check("two_reads.rsp_valid", rsp_valid, 4'b0101);
      check("two_reads.rdata0", rsp_rdata[0], 64'hA);
      check("two_reads.rdata2", rsp_rdata[2], 64'hB);

      @(negedge clk);
      req_valid = 4'b0100;
      req_addr[2] = 10'h020;
      cycle("mid_reset.grant");
      check("mid_reset.granted", req_ready, 4'b0100);
      @(negedge clk);
      req_valid = '0;
      rst_n = 1'b0;
      cycle("mid_reset.in_reset");
      check("mid_reset.no_rsp_t1", rsp_valid, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
      cycle("mid_reset.after");
      check("mid_reset.no_rsp_t2", rsp_valid, 4'b0000);

      for (int i = 0; i < NR; i++) begin
         req_addr[i] = 10'(10'h200 + i);
         wait_cnt[i] = 0;
      end
      max_wait = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         req_valid = '1;
         cycle("fair");
         check("fair.pair", req_ready, (c % 2 == 0) ? 4'b0011 : 4'b1100);
         for (int i = 0; i < NR; i++) begin
            wait_cnt[i] = req_ready[i] ? 0 : wait_cnt[i] + 1;
            if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
         end
      end
      check("fair.max_wait_le2", (max_wait <= 2), 1'b1);

      @(negedge clk);
      req_valid = '0;
      rst_n = 1'b0;
      cycle("pre_conflict.reset");
      @(negedge clk);
      rst_n = 1'b1;
      cycle("pre_conflict.idle");
      conflict_run("conflict1");
      conflict_run("conflict2");
      conflict_run("conflict3");
`ifdef RAM_ARB_PERF_CNT_EN
      check("perf.conflict_cnt", perf_conflict_cnt, 32'd3);
      check("perf.grant_cnt1",   perf_grant_cnt[1], 32'd3);
      check("perf.grant_cnt3",   perf_grant_cnt[3], 32'd3);
`else
      check("perf.conflict_tied", perf_conflict_cnt, 32'd0);
      check("perf.grant_tied",    perf_grant_cnt, '0);
`endif

      m_ready = '1;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         rst_n = ($urandom_range(0, 49) != 0);
         new_reqs();
         cycle("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
